dht11_emulator: RTL and testbench
=================================

DHT11_EMULATOR -- requirements
Module: dht11_emulator

Interface
- REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 50: system clock in MHz; 1 us tick = CLK_FREQ_MHZ cycles.
- REQ-002 SHALL have parameter START_MIN_US, default 18000: minimum host low pulse accepted as a start request.
- REQ-003 SHALL have parameter RESP_DELAY_US, default 30: delay from host release to the response low.
- REQ-004 SHALL have port clock, input, 1: the single system clock; all logic on its rising edge.
- REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-006 SHALL have port transmission_line, inout, 1: open-drain single-wire bus; driven 0 or Z only, never 1.
- REQ-007 SHALL have port hum_int, input, 8: humidity integer byte.
- REQ-008 SHALL have port hum_dec, input, 8: humidity decimal byte.
- REQ-009 SHALL have port temp_int, input, 8: temperature integer byte.
- REQ-010 SHALL have port temp_dec, input, 8: temperature decimal byte.
- REQ-011 SHALL have port inject_checksum_error, input, 1: when 1, the transmitted checksum is corrupted.
- REQ-012 SHALL have port busy, output, 1: high from start acceptance until the frame ends.
- REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when a frame completes.

Function
- REQ-014 SHALL sample transmission_line through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle latency).
- REQ-015 SHALL derive a 1 us tick from a prescaler counting 0..CLK_FREQ_MHZ-1; prescaler restarts on every state change.
- REQ-016 SHALL implement states: IDLE, HOST_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
- REQ-017 IDLE: line released; synchronized line = 0 -> HOST_LOW, us counter cleared.
- REQ-018 HOST_LOW: count us while the line is low; on release, count >= START_MIN_US -> RESP_DELAY; otherwise -> IDLE with no response (glitch rejection).
- REQ-019 HOST_LOW us counter SHALL be 15 bits and saturate at 32767; arbitrarily long host lows are accepted.
- REQ-020 On entry to RESP_DELAY SHALL snapshot the 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, chk}; later input changes do not affect the frame in flight.
- REQ-021 chk SHALL be the modulo-256 sum of the four data bytes, XOR 8'h01 when inject_checksum_error = 1 at snapshot time.
- REQ-022 RESP_DELAY: release for RESP_DELAY_US us -> RESP_LOW.
- REQ-023 RESP_LOW: drive 0 for 80 us -> RESP_HIGH; RESP_HIGH: release for 80 us -> BIT_LOW.
- REQ-024 Bits SHALL be sent MSB first (frame bit 39 first), 6-bit index counting 39 down to 0.
- REQ-025 BIT_LOW: drive 0 for 50 us -> BIT_HIGH; BIT_HIGH: release for 26 us when bit = 0, 70 us when bit = 1.
- REQ-026 After BIT_HIGH: index > 0 -> decrement, BIT_LOW; index = 0 -> END_LOW.
- REQ-027 END_LOW: drive 0 for 50 us, then release, pulse frame_done for one cycle, -> IDLE.
- REQ-028 busy SHALL be 1 in RESP_DELAY through END_LOW inclusive and 0 in IDLE and HOST_LOW.
- REQ-029 The line SHALL NOT be monitored while busy; a host pulling low mid-frame does not abort or restart the frame.
- REQ-030 A new start SHALL be recognized only after returning to IDLE; the first low sample in IDLE begins HOST_LOW.
- REQ-031 Total frame duration from host release SHALL be RESP_DELAY_US + 160 + 40*50 + sum(bit highs) + 50 us, within +/-2 clocks.

Reset
- REQ-032 On reset = 1, state SHALL be IDLE, line released (Z), busy = 0, frame_done = 0, counters and snapshot cleared, synchronizer set to 1.
- REQ-033 Reset asserted mid-frame SHALL release the line immediately (asynchronous) with no frame_done pulse.

Verification
- REQ-034 Host low 18 ms, release; hum_int 0x37, hum_dec 0, temp_int 0x19, temp_dec 0 -> 30 us release, 80 us low, 80 us high, bits decode 0x37,0x00,0x19,0x00,0x50, frame_done once.
- REQ-035 Same inputs with inject_checksum_error = 1 -> checksum byte received as 0x51; data bytes unchanged.
- REQ-036 Host low 10 ms then release -> no drive on line, busy stays 0, FSM back in IDLE.
- REQ-037 Inputs changed to 0xFF during bit transfer -> received frame still 0x37,0x00,0x19,0x00,0x50.
- REQ-038 Reset pulsed during bit 20 -> line released within the same cycle, busy = 0, no frame_done; next 18 ms start produces a full correct frame.
- REQ-039 Bytes 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC (modulo wrap); every bit-1 high measures 70 us +/-2 clocks.

Source files
------------

// File: rtl/dht11_emulator.sv
// dht11_emulator: DHT11 humidity/temperature sensor emulator on an open-drain single-wire bus
module dht11_emulator #(
    parameter int CLK_FREQ_MHZ  = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        transmission_line,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       inject_checksum_error,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_RESP_DELAY, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    localparam logic [15:0] PRE_LAST   = 16'(CLK_FREQ_MHZ - 1);
    // The response delay starts part-way into its first microsecond so that the
    // synchronizer plus decision latency is absorbed and the frame stays on time
    localparam logic [15:0] PRE_COMP   = (CLK_FREQ_MHZ > 2) ? 16'd2 : PRE_LAST;
    localparam logic [14:0] START_MIN  = (START_MIN_US > 32767) ? 15'h7fff : 15'(START_MIN_US);
    localparam logic [14:0] DELAY_LAST = 15'(RESP_DELAY_US - 1);

    state_t      r_state;
    logic [1:0]  r_sync;
    logic [15:0] r_pre;
    logic [14:0] r_us;
    logic [39:0] r_frame;
    logic [5:0]  r_idx;
    logic        r_drive_low;
    logic        r_busy;
    logic        r_done;
    logic        w_line;
    logic        w_tick;
    logic        w_bit;
    logic [14:0] w_high_last;
    logic [7:0]  w_chk;

    assign transmission_line = r_drive_low ? 1'b0 : 1'bz;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign w_line      = r_sync[1];
    assign w_tick      = r_pre == PRE_LAST;
    assign w_bit       = r_frame[r_idx];
    assign w_high_last = w_bit ? 15'd69 : 15'd25;
    assign w_chk       = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'd0, inject_checksum_error};

    // Two-flop synchronizer for the asynchronous bus level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], transmission_line};
    end

    // State entry: restart timing and set the bus drive for the new state
    task automatic enter(input state_t s);
        r_state     <= s;
        r_pre       <= (s == S_RESP_DELAY) ? PRE_COMP : 16'd0;
        r_us        <= 15'd0;
        r_drive_low <= (s == S_RESP_LOW) || (s == S_BIT_LOW) || (s == S_END_LOW);
    endtask

    // Protocol FSM with microsecond timing, frame snapshot and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pre       <= 16'd0;
            r_us        <= 15'd0;
            r_frame     <= 40'd0;
            r_idx       <= 6'd0;
            r_drive_low <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pre  <= w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_tick && r_us != 15'h7fff) r_us <= r_us + 15'd1;
            case (r_state)
                S_IDLE: if (!w_line) enter(S_HOST_LOW);
                S_HOST_LOW: begin
                    if (w_line && r_us >= START_MIN) begin
                        r_frame <= {hum_int, hum_dec, temp_int, temp_dec, w_chk};
                        r_idx   <= 6'd39;
                        r_busy  <= 1'b1;
                        enter(S_RESP_DELAY);
                    end else if (w_line) enter(S_IDLE);
                end
                S_RESP_DELAY: if (w_tick && r_us == DELAY_LAST) enter(S_RESP_LOW);
                S_RESP_LOW:   if (w_tick && r_us == 15'd79) enter(S_RESP_HIGH);
                S_RESP_HIGH:  if (w_tick && r_us == 15'd79) enter(S_BIT_LOW);
                S_BIT_LOW:    if (w_tick && r_us == 15'd49) enter(S_BIT_HIGH);
                S_BIT_HIGH: begin
                    if (w_tick && r_us == w_high_last && r_idx == 6'd0) enter(S_END_LOW);
                    else if (w_tick && r_us == w_high_last) begin
                        r_idx <= r_idx - 6'd1;
                        enter(S_BIT_LOW);
                    end
                end
                S_END_LOW: begin
                    if (w_tick && r_us == 15'd49) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        enter(S_IDLE);
                    end
                end
                default: enter(S_IDLE);
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_emulator.sv
// tb_dht11_emulator: host-side bench decoding DHT11 frames from bus pulse widths
module tb_dht11_emulator;
    localparam int CLK  = 2;
    localparam int SMIN = 100;
    localparam int RDLY = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       host_low = 1'b0;
    logic       inject = 1'b0;
    logic [7:0] hi = 8'd0, hd = 8'd0, ti = 8'd0, td = 8'd0;
    logic       busy, frame_done;
    wire        transmission_line;
    int         errors = 0, checks = 0, done_cnt = 0, busy_cycles = 0;
    int         runs[$];

    pullup (transmission_line);
    assign transmission_line = host_low ? 1'b0 : 1'bz;

    dht11_emulator #(.CLK_FREQ_MHZ(CLK), .START_MIN_US(SMIN), .RESP_DELAY_US(RDLY)) dut (
        .clock(clock), .reset(reset), .transmission_line(transmission_line),
        .hum_int(hi), .hum_dec(hd), .temp_int(ti), .temp_dec(td),
        .inject_checksum_error(inject), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (frame_done === 1'b1) done_cnt++;

    // Reference frame: four bytes plus their modulo-256 sum, LSB flipped on injected error
    function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d, input logic inj);
        int s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        return {a, b, c, d, 8'(s) ^ {7'd0, inj}};
    endfunction

    // Number of captured pulse widths that deviate from the protocol timing by more than 2 clocks
    function automatic int timing_errs(input logic [39:0] f);
        int e[$];
        int n = 0;
        e.push_back(RDLY * CLK); e.push_back(80 * CLK); e.push_back(80 * CLK);
        for (int i = 39; i >= 0; i--) begin
            e.push_back(50 * CLK);
            e.push_back((f[i] ? 70 : 26) * CLK);
        end
        e.push_back(50 * CLK);
        if (runs.size() != e.size() + 1) return 999;
        foreach (e[i]) if (runs[i] > e[i] + 2 || runs[i] < e[i] - 2) n++;
        return n;
    endfunction

    function automatic int model_total(input logic [39:0] f);
        int t = RDLY + 160 + 40 * 50 + 50;
        for (int i = 0; i < 40; i++) t += f[i] ? 70 : 26;
        return t * CLK;
    endfunction

    function automatic int measured_total();
        int t = 0;
        for (int i = 0; i + 1 < runs.size(); i++) t += runs[i];
        return t;
    endfunction

    function automatic logic [39:0] decode();
        logic [39:0] f = '0;
        for (int i = 0; i < 40; i++) if (4 + 2 * i < runs.size()) f[39-i] = runs[4+2*i] > 48 * CLK;
        return f;
    endfunction

    task automatic host_start(input int us);
        @(posedge clock); #1 host_low = 1'b1;
        repeat (us * CLK) @(posedge clock);
        #1 host_low = 1'b0;
    endtask

    // Record alternating bus level run lengths (starting high) until the bus idles high
    task automatic capture();
        logic cur;
        int   len;
        runs.delete();
        busy_cycles = 0;
        cur = 1'b1;
        len = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cycles++;
            if (transmission_line === cur) len++;
            else begin
                runs.push_back(len);
                cur = transmission_line;
                len = 1;
            end
            if (cur === 1'b1 && len > 400) break;
        end
        runs.push_back(len);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (transmission_line !== 1'b1) begin errors++; $display("FAIL reset_line got=%b exp=1", transmission_line); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (20) @(negedge clock);
        checks++; if (transmission_line !== 1'b1) begin errors++; $display("FAIL idle_line got=%b exp=1", transmission_line); end
        checks++; if (busy !== 1'b0 || done_cnt != 0) begin errors++; $display("FAIL idle_busy busy=%b done=%0d exp 0/0", busy, done_cnt); end
    endtask

    task automatic test_nominal();
        logic [39:0] exp;
        int d0;
        hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00; inject = 1'b0;
        exp = model_frame(hi, hd, ti, td, inject);
        d0 = done_cnt;
        host_start(SMIN + 20);
        capture();
        checks++; if (decode() !== exp) begin errors++; $display("FAIL nominal_frame got=%h exp=%h", decode(), exp); end
        checks++; if (timing_errs(exp) != 0) begin errors++; $display("FAIL nominal_timing bad_runs=%0d exp=0", timing_errs(exp)); end
        checks++; if (measured_total() > model_total(exp) + 2 || measured_total() < model_total(exp) - 2)
            begin errors++; $display("FAIL nominal_total got=%0d exp=%0d", measured_total(), model_total(exp)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL nominal_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy_cycles > model_total(exp) + 3 || busy_cycles < model_total(exp) - 3)
            begin errors++; $display("FAIL nominal_busy got=%0d exp=%0d", busy_cycles, model_total(exp)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_checksum_error();
        logic [39:0] exp;
        hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00; inject = 1'b1;
        exp = model_frame(hi, hd, ti, td, inject);
        host_start(SMIN + 20);
        capture();
        inject = 1'b0;
        checks++; if (decode() !== exp) begin errors++; $display("FAIL chkerr_frame got=%h exp=%h", decode(), exp); end
        checks++; if (timing_errs(exp) != 0) begin errors++; $display("FAIL chkerr_timing bad_runs=%0d exp=0", timing_errs(exp)); end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        host_start($urandom_range(SMIN / 2, 5));
        capture();
        checks++; if (runs.size() != 1) begin errors++; $display("FAIL glitch_line runs=%0d exp=1", runs.size()); end
        checks++; if (busy_cycles != 0) begin errors++; $display("FAIL glitch_busy got=%0d exp=0", busy_cycles); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL glitch_done got=%0d exp=%0d", done_cnt, d0); end
    endtask

    task automatic test_input_change();
        logic [39:0] exp;
        hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00; inject = 1'b0;
        exp = model_frame(hi, hd, ti, td, inject);
        host_start(SMIN + 20);
        fork
            capture();
            begin
                repeat (2000) @(posedge clock);
                #1 hi = 8'hFF; hd = 8'hFF; ti = 8'hFF; td = 8'hFF; inject = 1'b1;
            end
        join
        inject = 1'b0;
        checks++; if (decode() !== exp) begin errors++; $display("FAIL inchange_frame got=%h exp=%h", decode(), exp); end
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] exp;
        logic        prev = 1'b1;
        int          falls = 0;
        int          d0 = done_cnt;
        hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00; inject = 1'b0;
        exp = model_frame(hi, hd, ti, td, inject);
        host_start(SMIN + 20);
        for (int c = 0; c < 10000 && falls < 22; c++) begin
            @(negedge clock);
            if (prev === 1'b1 && transmission_line === 1'b0) falls++;
            prev = transmission_line;
        end
        checks++; if (falls != 22) begin errors++; $display("FAIL midrst_reach falls=%0d exp=22", falls); end
        repeat (20) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checks++; if (transmission_line !== 1'b1) begin errors++; $display("FAIL midrst_line got=%b exp=1", transmission_line); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        repeat (300) @(negedge clock);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrst_done got=%0d exp=%0d", done_cnt, d0); end
        host_start(SMIN + 20);
        capture();
        checks++; if (decode() !== exp) begin errors++; $display("FAIL midrst_frame got=%h exp=%h", decode(), exp); end
        checks++; if (timing_errs(exp) != 0) begin errors++; $display("FAIL midrst_timing bad_runs=%0d exp=0", timing_errs(exp)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL midrst_done2 got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_all_ones();
        logic [39:0] exp;
        logic [39:0] got;
        hi = 8'hFF; hd = 8'hFF; ti = 8'hFF; td = 8'hFF; inject = 1'b0;
        exp = model_frame(hi, hd, ti, td, inject);
        host_start(SMIN + 20);
        capture();
        got = decode();
        checks++; if (got !== exp) begin errors++; $display("FAIL ones_frame got=%h exp=%h", got, exp); end
        checks++; if (got[7:0] !== 8'hFC) begin errors++; $display("FAIL ones_chk got=%h exp=fc", got[7:0]); end
        checks++; if (timing_errs(exp) != 0) begin errors++; $display("FAIL ones_timing bad_runs=%0d exp=0", timing_errs(exp)); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp;
        int d0 = done_cnt;
        hi = 8'($urandom); hd = 8'($urandom); ti = 8'($urandom); td = 8'($urandom);
        inject = 1'($urandom);
        exp = model_frame(hi, hd, ti, td, inject);
        host_start(SMIN + $urandom_range(60, 10));
        capture();
        checks++; if (decode() !== exp) begin errors++; $display("FAIL random_frame got=%h exp=%h", decode(), exp); end
        checks++; if (timing_errs(exp) != 0) begin errors++; $display("FAIL random_timing bad_runs=%0d exp=0", timing_errs(exp)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL random_done got=%0d exp=1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_checksum_error();
        test_glitch();
        test_input_change();
        test_reset_mid_frame();
        test_all_ones();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
